// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single LC-3 memory port: CPU has priority, debug/loader
// port is guaranteed service by a starvation counter. Reads wait MEM_LAT cycles.
module mem_arbiter #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned MEM_LAT  = 1,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              cpuReq,
   input  logic              cpuWE,
   input  logic [ADDR_W-1:0] cpuAddr,
   input  logic [DATA_W-1:0] cpuWData,
   output logic              cpuGnt,
   output logic              cpuRValid,
   output logic [DATA_W-1:0] cpuRData,
   input  logic              dbgReq,
   input  logic              dbgWE,
   input  logic [ADDR_W-1:0] dbgAddr,
   input  logic [DATA_W-1:0] dbgWData,
   output logic              dbgGnt,
   output logic              dbgRValid,
   output logic [DATA_W-1:0] dbgRData,
   output logic              memEn,
   output logic              memWE,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWData,
   input  logic [DATA_W-1:0] memRData
);

   localparam int unsigned CNT_W    = 2;
   localparam int unsigned STARVE_W = 4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_WAIT = 2'd1,
      S_RESP    = 2'd2
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_wait_cnt;
   logic [STARVE_W-1:0] r_starve_cnt;
   logic                r_owner_dbg;
   logic                r_cpu_rvalid;
   logic                r_dbg_rvalid;
   logic [DATA_W-1:0]   r_cpu_rdata;
   logic [DATA_W-1:0]   r_dbg_rdata;

   logic                w_cpu_win;
   logic                w_dbg_win;
   logic                w_starved;

   assign w_starved = (r_starve_cnt == STARVE_W'(MAX_WAIT));

   // Same-cycle arbitration; nothing is granted outside IDLE or while in reset
   always_comb begin
      w_cpu_win = 1'b0;
      w_dbg_win = 1'b0;
      if (r_state == S_IDLE && resetN) begin
         if (dbgReq && (!cpuReq || w_starved)) begin
            w_dbg_win = 1'b1;
         end else if (cpuReq) begin
            w_cpu_win = 1'b1;
         end
      end
   end

   // Memory-side mux; fields are zero whenever no access is strobed
   always_comb begin
      memWE    = 1'b0;
      memAddr  = '0;
      memWData = '0;
      if (w_cpu_win) begin
         memWE    = cpuWE;
         memAddr  = cpuAddr;
         memWData = cpuWData;
      end else if (w_dbg_win) begin
         memWE    = dbgWE;
         memAddr  = dbgAddr;
         memWData = dbgWData;
      end
   end

   assign cpuGnt    = w_cpu_win;
   assign dbgGnt    = w_dbg_win;
   assign memEn     = w_cpu_win | w_dbg_win;
   assign cpuRValid = r_cpu_rvalid;
   assign dbgRValid = r_dbg_rvalid;
   assign cpuRData  = r_cpu_rdata;
   assign dbgRData  = r_dbg_rdata;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state      <= S_IDLE;
         r_wait_cnt   <= '0;
         r_starve_cnt <= '0;
         r_owner_dbg  <= 1'b0;
         r_cpu_rvalid <= 1'b0;
         r_dbg_rvalid <= 1'b0;
         r_cpu_rdata  <= '0;
         r_dbg_rdata  <= '0;
      end else begin
         r_cpu_rvalid <= 1'b0;
         r_dbg_rvalid <= 1'b0;

         // Starvation count only grows while the debug port is actually waiting
         if (!dbgReq || w_dbg_win) begin
            r_starve_cnt <= '0;
         end else if (w_cpu_win && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
         end

         case (r_state)
            S_IDLE: begin
               if (memEn && !memWE) begin
                  r_owner_dbg <= w_dbg_win;
                  r_wait_cnt  <= CNT_W'(MEM_LAT - 1);
                  r_state     <= S_RD_WAIT;
               end
            end
            S_RD_WAIT: begin
               if (r_wait_cnt == '0) begin
                  if (r_owner_dbg) begin
                     r_dbg_rdata  <= memRData;
                     r_dbg_rvalid <= 1'b1;
                  end else begin
                     r_cpu_rdata  <= memRData;
                     r_cpu_rvalid <= 1'b1;
                  end
                  r_state <= S_RESP;
               end else begin
                  r_wait_cnt <= r_wait_cnt - CNT_W'(1);
               end
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
